addreq_driver: RTL and testbench

Initiator and response collector for the req/ack adder interface. It generates a programmed sequence of operand pairs, issues each one to a downstream req/ack adder, accepts each result, and optionally checks that result against the expected sum. It sits at the other end of the adder handshake: it drives the adder's input side and sinks the adder's output side. It is used as an on-chip traffic generator and self-test engine, with one transaction outstanding at a time.

---
 rtl/addreq_pkg.sv | 23 ++
 rtl/addreq_opgen.sv | 62 ++++++
 rtl/addreq_driver.sv | 197 +++++++++++++++++++
 tb/tb_addreq_driver.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addreq_pkg.sv
// Shared types and default widths for the req/ack adder traffic generator.
package addreq_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        COLLECT = 2'd2,
        FIN     = 2'd3
    } state_e;

    // Job configuration as sampled on start
    typedef struct packed {
        logic [DEF_CNT_W-1:0]  count;
        logic [DEF_DATA_W-1:0] base_a;
        logic [DEF_DATA_W-1:0] base_b;
        logic [DEF_DATA_W-1:0] step_a;
        logic [DEF_DATA_W-1:0] step_b;
    } cfg_t;

endpackage

// File: rtl/addreq_opgen.sv
// Operand generator: A/B registers, per-transaction step adders and remaining-transaction counter.
module addreq_opgen #(
    parameter int unsigned DATA_W = addreq_pkg::DEF_DATA_W,
    parameter int unsigned CNT_W  = addreq_pkg::DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              next,
    input  addreq_pkg::cfg_t  cfg,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              last_c
);
    import addreq_pkg::*;

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] step_a_q, step_a_d;
    logic [DATA_W-1:0] step_b_q, step_b_d;
    logic [CNT_W-1:0]  rem_q, rem_d;

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        step_a_d = step_a_q;
        step_b_d = step_b_q;
        rem_d    = rem_q;
        if (load) begin
            a_d      = DATA_W'(cfg.base_a);
            b_d      = DATA_W'(cfg.base_b);
            step_a_d = DATA_W'(cfg.step_a);
            step_b_d = DATA_W'(cfg.step_b);
            rem_d    = CNT_W'(cfg.count);
        end else if (next) begin
            a_d   = a_q + step_a_q;
            b_d   = b_q + step_b_q;
            rem_d = rem_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            step_a_q <= '0;
            step_b_q <= '0;
            rem_q    <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            step_a_q <= step_a_d;
            step_b_q <= step_b_d;
            rem_q    <= rem_d;
        end
    end

    assign op_a   = a_q;
    assign op_b   = b_q;
    assign last_c = (rem_q == CNT_W'(1));

endmodule

// File: rtl/addreq_driver.sv
// Req/ack adder initiator and result collector, one transaction outstanding.
// Optional result checker enabled by defining ADDREQ_DRIVER_CHECK_EN.
module addreq_driver #(
    parameter int unsigned DATA_W      = addreq_pkg::DEF_DATA_W,
    parameter int unsigned CNT_W       = addreq_pkg::DEF_CNT_W,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic [DATA_W-1:0] cfg_base_a,
    input  logic [DATA_W-1:0] cfg_base_b,
    input  logic [DATA_W-1:0] cfg_step_a,
    input  logic [DATA_W-1:0] cfg_step_b,
    output logic              o_req,
    output logic [DATA_W-1:0] o_data,
    output logic [DATA_W-1:0] o_datb,
    input  logic              o_ack,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_datc,
    output logic              i_ack,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [DATA_W-1:0] res_last,
    output logic [CNT_W-1:0]  err_cnt
);
    import addreq_pkg::*;

    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic [DATA_W-1:0] res_last_q, res_last_d;
    logic              o_req_q, o_req_d;
    logic              i_ack_q, i_ack_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    cfg_t              cfg_in;
    logic              accept;
    logic              o_hs;
    logic              i_hs;
    logic              expired;
    logic              last_c;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    assign accept  = (state_q == IDLE) && start && (cfg_count != '0);
    assign o_hs    = o_req_q & o_ack;
    assign i_hs    = i_ack_q & i_req;
    assign expired = (wait_q == WAIT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cfg_in        = '0;
        cfg_in.count  = DEF_CNT_W'(cfg_count);
        cfg_in.base_a = DEF_DATA_W'(cfg_base_a);
        cfg_in.base_b = DEF_DATA_W'(cfg_base_b);
        cfg_in.step_a = DEF_DATA_W'(cfg_step_a);
        cfg_in.step_b = DEF_DATA_W'(cfg_step_b);
    end

    addreq_opgen #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_opgen (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .next   (i_hs),
        .cfg    (cfg_in),
        .op_a   (op_a),
        .op_b   (op_b),
        .last_c (last_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a handshake on the final allowed cycle wins over the timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (cfg_count == '0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                if (o_hs) begin
                    state_d = COLLECT;
                end else if (expired) begin
                    state_d = FIN;
                end
            end
            COLLECT: begin
                if (i_hs) begin
                    state_d = last_c ? FIN : ISSUE;
                end else if (expired) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake strobes are decoded from the next state so they align with it
    always_comb begin
        o_req_d    = (state_d == ISSUE);
        i_ack_d    = (state_d == COLLECT);
        busy_d     = (state_d == ISSUE) || (state_d == COLLECT);
        done_d     = (state_d == FIN);
        res_last_d = i_hs ? i_datc : res_last_q;
        timeout_d  = timeout_q;
        wait_d     = '0;
        if (accept) begin
            timeout_d = 1'b0;
        end else if (((state_q == ISSUE) && !o_hs) || ((state_q == COLLECT) && !i_hs)) begin
            if (expired) begin
                timeout_d = 1'b1;
            end else begin
                wait_d = wait_q + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q     <= '0;
            timeout_q  <= 1'b0;
            res_last_q <= '0;
            o_req_q    <= 1'b0;
            i_ack_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wait_q     <= wait_d;
            timeout_q  <= timeout_d;
            res_last_q <= res_last_d;
            o_req_q    <= o_req_d;
            i_ack_q    <= i_ack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef ADDREQ_DRIVER_CHECK_EN
    logic [CNT_W-1:0]  err_q, err_d;
    logic [DATA_W-1:0] expected_c;

    // Operands still hold the current transaction while its result is collected
    assign expected_c = op_a + op_b;

    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = '0;
        end else if (i_hs && (i_datc != expected_c) && (err_q != '1)) begin
            err_d = err_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

    assign o_req    = o_req_q;
    assign o_data   = op_a;
    assign o_datb   = op_b;
    assign i_ack    = i_ack_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign timeout  = timeout_q;
    assign res_last = res_last_q;

endmodule

// File: tb/tb_addreq_driver.sv
// Directed self-checking bench for addreq_driver; the bench plays the downstream adder.
module tb_addreq_driver;

    localparam int unsigned TO = 16;
`ifdef ADDREQ_DRIVER_CHECK_EN
    localparam logic [15:0] EXP_ERR = 16'd1;
`else
    localparam logic [15:0] EXP_ERR = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_count;
    logic [31:0] cfg_base_a, cfg_base_b, cfg_step_a, cfg_step_b;
    logic        o_req, o_ack, i_req, i_ack;
    logic [31:0] o_data, o_datb, i_datc, res_last;
    logic        busy, done, timeout;
    logic [15:0] err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    addreq_driver #(
        .DATA_W      (32),
        .CNT_W       (16),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_count  (cfg_count),
        .cfg_base_a (cfg_base_a),
        .cfg_base_b (cfg_base_b),
        .cfg_step_a (cfg_step_a),
        .cfg_step_b (cfg_step_b),
        .o_req      (o_req),
        .o_data     (o_data),
        .o_datb     (o_datb),
        .o_ack      (o_ack),
        .i_req      (i_req),
        .i_datc     (i_datc),
        .i_ack      (i_ack),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .res_last   (res_last),
        .err_cnt    (err_cnt)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [15:0] cnt, input logic [31:0] ba, input logic [31:0] bb,
                          input logic [31:0] sa, input logic [31:0] sb);
        cfg_count  = cnt;
        cfg_base_a = ba;
        cfg_base_b = bb;
        cfg_step_a = sa;
        cfg_step_b = sb;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // One adder transaction: accept operands after ack_wait stall cycles, answer after res_wait
    task automatic txn(input logic [31:0] ea, input logic [31:0] eb, input int ack_wait,
                       input int res_wait, input bit bad);
        int          cyc;
        logic [31:0] r;
        cyc = 0;
        while (o_req !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("o_req_up", o_req, 1);
        chk("busy_issue", busy, 1);
        chk("op_a", o_data, ea);
        chk("op_b", o_datb, eb);
        for (int k = 0; k < ack_wait; k++) begin
            tick();
            chk("hold_a", o_data, ea);
            chk("hold_b", o_datb, eb);
            chk("hold_req", o_req, 1);
        end
        o_ack = 1'b1;
        tick();
        o_ack = 1'b0;
        chk("req_drop", o_req, 0);
        chk("iack_up", i_ack, 1);
        for (int k = 0; k < res_wait; k++) begin
            tick();
            chk("iack_hold", i_ack, 1);
        end
        r      = ea + eb + (bad ? 32'd1 : 32'd0);
        i_req  = 1'b1;
        i_datc = r;
        tick();
        i_req  = 1'b0;
        chk("iack_drop", i_ack, 0);
        chk("res_last", res_last, r);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        cfg_count  = '0;
        cfg_base_a = '0;
        cfg_base_b = '0;
        cfg_step_a = '0;
        cfg_step_b = '0;
        o_ack      = 1'b0;
        i_req      = 1'b0;
        i_datc     = '0;
        repeat (2) @(negedge clk);

        chk("rst_o_req", o_req, 0);
        chk("rst_i_ack", i_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_res_last", res_last, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        tick();

        // Normal job, ideal adder
        launch(16'd4, 32'd1, 32'd2, 32'd1, 32'd1);
        txn(32'd1, 32'd2, 0, 0, 1'b0);
        txn(32'd2, 32'd3, 0, 0, 1'b0);
        txn(32'd3, 32'd4, 0, 0, 1'b0);
        txn(32'd4, 32'd5, 0, 0, 1'b0);
        chk("norm_done", done, 1);
        chk("norm_busy_fin", busy, 0);
        chk("norm_res_last", res_last, 32'd9);
        chk("norm_err_cnt", err_cnt, 0);
        chk("norm_timeout", timeout, 0);
        tick();
        chk("norm_done_once", done, 0);

        // Operand wrap-around
        launch(16'd2, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd1);
        txn(32'hFFFF_FFFF, 32'd1, 0, 0, 1'b0);
        chk("wrap_res0", res_last, 32'h0000_0000);
        txn(32'h0000_0000, 32'd2, 0, 0, 1'b0);
        chk("wrap_res1", res_last, 32'h0000_0002);
        chk("wrap_err_cnt", err_cnt, 0);
        chk("wrap_done", done, 1);
        tick();

        // Backpressure on both phases
        launch(16'd1, 32'd10, 32'd20, 32'd3, 32'd4);
        txn(32'd10, 32'd20, 5, 3, 1'b0);
        chk("bp_done", done, 1);
        chk("bp_res_last", res_last, 32'd30);
        tick();

        // Start pulse mid-job must not disturb the job
        launch(16'd2, 32'd5, 32'd6, 32'd1, 32'd1);
        cfg_count  = 16'd0;
        cfg_base_a = 32'd99;
        cfg_base_b = 32'd98;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        chk("mid_start_busy", busy, 1);
        chk("mid_start_done", done, 0);
        txn(32'd5, 32'd6, 0, 0, 1'b0);
        txn(32'd6, 32'd7, 0, 0, 1'b0);
        chk("mid_start_end", done, 1);
        tick();

        // Timeout with o_ack held low
        launch(16'd3, 32'd1, 32'd1, 32'd0, 32'd0);
        chk("to_req_up", o_req, 1);
        repeat (TO - 1) tick();
        chk("to_not_yet", timeout, 0);
        chk("to_req_held", o_req, 1);
        tick();
        chk("to_flag", timeout, 1);
        chk("to_done", done, 1);
        chk("to_req_drop", o_req, 0);
        chk("to_busy", busy, 0);
        tick();
        chk("to_done_once", done, 0);
        chk("to_sticky", timeout, 1);
        i_req  = 1'b1;
        i_datc = 32'hDEAD_BEEF;
        tick();
        chk("to_late_no_ack", i_ack, 0);
        i_req  = 1'b0;
        tick();

        // Result checker: transaction 2 of 3 returns a+b+1
        launch(16'd3, 32'd100, 32'd200, 32'd1, 32'd1);
        chk("chk_timeout_clr", timeout, 0);
        txn(32'd100, 32'd200, 0, 1, 1'b0);
        txn(32'd101, 32'd201, 1, 0, 1'b1);
        txn(32'd102, 32'd202, 0, 0, 1'b0);
        chk("chk_done", done, 1);
        chk("chk_err_cnt", err_cnt, EXP_ERR);
        tick();

        // count=0 start
        launch(16'd0, 32'd1, 32'd1, 32'd1, 32'd1);
        chk("cnt0_done", done, 1);
        chk("cnt0_no_req", o_req, 0);
        chk("cnt0_busy", busy, 0);
        tick();
        chk("cnt0_done_once", done, 0);
        chk("cnt0_no_req2", o_req, 0);

        // Asynchronous reset in COLLECT
        launch(16'd2, 32'd7, 32'd8, 32'd1, 32'd1);
        chk("ar_req_up", o_req, 1);
        o_ack = 1'b1;
        tick();
        o_ack = 1'b0;
        chk("ar_collect", i_ack, 1);
        #1 rst = 1'b1;
        #1;
        chk("ar_i_ack", i_ack, 0);
        chk("ar_o_req", o_req, 0);
        chk("ar_busy", busy, 0);
        chk("ar_o_data", o_data, 0);
        chk("ar_res_last", res_last, 0);
        chk("ar_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("ar_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
